// File: rtl/imm_extend_unit.sv
// imm_extend_unit: extends a raw immediate (sign / zero / upper / branch offset)
// at accept time and buffers the result in a 2-entry FIFO with valid/ready handshakes.
// Optional feature macro: IMM_EXT_STATS_EN adds the 16-bit xfer_count accept counter.
module imm_extend_unit #(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [IN_W-1:0]    in_imm,
   input  logic [1:0]         in_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   out_data
`ifdef IMM_EXT_STATS_EN
   ,
   output logic [15:0]        xfer_count
`endif
);

   localparam int unsigned EXT_W = OUT_W - IN_W;
   localparam int unsigned DEPTH = 2;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } occ_e;

   occ_e               state_q, state_d;
   logic               wr_ptr_q, wr_ptr_d;
   logic               rd_ptr_q, rd_ptr_d;
   logic [OUT_W-1:0]   mem_q [DEPTH];
   logic [OUT_W-1:0]   mem_d [DEPTH];
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [OUT_W-1:0]   out_data_q, out_data_d;

   logic               accept_c;
   logic               drain_c;
   logic [OUT_W-1:0]   sext_c;
   logic [OUT_W-1:0]   ext_c;

   // Handshake events, qualified only by registered flags
   always_comb begin
      accept_c = in_valid & in_ready_q;
      drain_c  = out_valid_q & out_ready;
   end

   // Immediate extension for the four modes
   always_comb begin
      sext_c = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
      ext_c  = sext_c;
      case (in_mode)
         2'b00:   ext_c = sext_c;
         2'b01:   ext_c = {{EXT_W{1'b0}}, in_imm};
         2'b10:   ext_c = {in_imm, {EXT_W{1'b0}}};
         default: ext_c = {sext_c[OUT_W-3:0], 2'b00};
      endcase
   end

   // Occupancy FSM, FIFO write/read and next output register values
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      for (int i = 0; i < int'(DEPTH); i++) begin
         mem_d[i] = mem_q[i];
      end

      if (accept_c) begin
         mem_d[wr_ptr_q] = ext_c;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (drain_c) begin
         rd_ptr_d = ~rd_ptr_q;
      end

      case (state_q)
         ST_EMPTY: begin
            if (accept_c) state_d = ST_ONE;
         end
         ST_ONE: begin
            if (accept_c && !drain_c)      state_d = ST_TWO;
            else if (drain_c && !accept_c) state_d = ST_EMPTY;
         end
         ST_TWO: begin
            if (drain_c) state_d = ST_ONE;
         end
         default: state_d = ST_EMPTY;
      endcase

      in_ready_d  = (state_d != ST_TWO);
      out_valid_d = (state_d != ST_EMPTY);
      out_data_d  = mem_d[rd_ptr_d];
   end

   // State, storage and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

`ifdef IMM_EXT_STATS_EN
   logic [15:0] xfer_count_q, xfer_count_d;

   // Accept counter, wraps naturally at 16 bits
   always_comb begin
      xfer_count_d = xfer_count_q;
      if (accept_c) xfer_count_d = xfer_count_q + 16'd1;
   end

   // Accept counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) xfer_count_q <= 16'd0;
      else        xfer_count_q <= xfer_count_d;
   end

   assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: directed vectors plus randomized
// traffic compared against a queue-based reference model.
module tb_imm_extend_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_imm;
   logic [1:0]  in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
`ifdef IMM_EXT_STATS_EN
   logic [15:0] xfer_count;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   int          acc_cnt = 0;

   imm_extend_unit #(.IN_W(16), .OUT_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_imm     (in_imm),
      .in_mode    (in_mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data)
`ifdef IMM_EXT_STATS_EN
      ,
      .xfer_count (xfer_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Arithmetic reference of the extension rules (value mod 2^32)
   function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
      longint s;
      longint r;
      longint m;
      m = 64'h1_0000_0000;
      s = (imm >= 16'h8000) ? longint'(imm) - 65536 : longint'(imm);
      case (mode)
         2'd0:    r = s;
         2'd1:    r = longint'(imm);
         2'd2:    r = longint'(imm) * 65536;
         default: r = s * 4;
      endcase
      r = ((r % m) + m) % m;
      return 32'(r);
   endfunction

   // Reference model: FIFO of depth 2 expressed as a queue
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         acc_cnt = 0;
      end else begin
         logic acc;
         logic drn;
         acc = in_valid && (exp_q.size() < 2);
         drn = out_ready && (exp_q.size() > 0);
         if (drn) void'(exp_q.pop_front());
         if (acc) begin
            exp_q.push_back(ref_ext(in_imm, in_mode));
            acc_cnt++;
         end
      end
   end

   // Per-cycle monitor against the model
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_out_valid", 64'(out_valid), 64'd0);
         check("rst_in_ready", 64'(in_ready), 64'd1);
         check("rst_out_data", 64'(out_data), 64'd0);
      end else begin
         check("mon_out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
         check("mon_in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
         if (exp_q.size() > 0) check("mon_out_data", 64'(out_data), 64'(exp_q[0]));
      end
`ifdef IMM_EXT_STATS_EN
      check("mon_xfer_count", 64'(xfer_count), 64'(acc_cnt % 65536));
`endif
   end

   task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                        input logic ordy);
      in_valid  = v;
      in_imm    = imm;
      in_mode   = mode;
      out_ready = ordy;
   endtask

   // Single accept into an empty FIFO, result checked one cycle later
   task automatic send_one(input string tag, input logic [15:0] imm, input logic [1:0] mode,
                           input logic [31:0] exp);
      @(negedge clk);
      drive(1'b1, imm, mode, 1'b1);
      @(negedge clk);
      drive(1'b0, 16'h0, 2'd0, 1'b1);
      check(tag, 64'(out_data), 64'(exp));
      check({tag, "_v"}, 64'(out_valid), 64'd1);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 16'h0, 2'd0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      send_one("sign_neg", 16'hFFE2, 2'd0, 32'hFFFFFFE2);
      send_one("sign_pos", 16'h0028, 2'd0, 32'h00000028);
      send_one("zero_8001", 16'h8001, 2'd1, 32'h00008001);
      send_one("upper_8001", 16'h8001, 2'd2, 32'h80010000);
      send_one("branch_8001", 16'h8001, 2'd3, 32'hFFFE0004);
      send_one("branch_7fff", 16'h7FFF, 2'd3, 32'h0001FFFC);

      // Backpressure: three offered, two accepted, strict order on release
      @(negedge clk);
      drive(1'b1, 16'd1, 2'd0, 1'b0);
      @(negedge clk);
      check("bp_first", 64'(out_data), 64'd1);
      drive(1'b1, 16'd2, 2'd0, 1'b0);
      @(negedge clk);
      check("bp_full_rdy", 64'(in_ready), 64'd0);
      check("bp_hold1", 64'(out_data), 64'd1);
      drive(1'b1, 16'd3, 2'd0, 1'b0);
      @(negedge clk);
      check("bp_hold2", 64'(out_data), 64'd1);
      check("bp_hold_v", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_out2", 64'(out_data), 64'd2);
      check("bp_rdy_one", 64'(in_ready), 64'd1);
      @(negedge clk);
      check("bp_out3", 64'(out_data), 64'd3);
      check("bp_simul_v", 64'(out_valid), 64'd1);
      drive(1'b0, 16'h0, 2'd0, 1'b1);
      @(negedge clk);
      check("bp_empty", 64'(out_valid), 64'd0);

      // Reset mid-operation with two entries stored
      drive(1'b1, 16'h1234, 2'd1, 1'b0);
      @(negedge clk);
      drive(1'b1, 16'h5678, 2'd1, 1'b0);
      @(negedge clk);
      drive(1'b0, 16'h0, 2'd0, 1'b0);
      check("pre_rst_full", 64'(in_ready), 64'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_ready", 64'(in_ready), 64'd1);
      check("mid_rst_data", 64'(out_data), 64'd0);
      #1;
      rst_n = 1'b1;
      send_one("post_rst", 16'h00AB, 2'd1, 32'h000000AB);

      // Randomized traffic checked by the monitor
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         drive(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom), 1'($urandom_range(0, 2) != 0));
      end
      @(negedge clk);
      drive(1'b0, 16'h0, 2'd0, 1'b1);
      repeat (3) @(negedge clk);

`ifdef IMM_EXT_STATS_EN
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 16'h0001, 2'd0, 1'b1);
      repeat (65537) @(negedge clk);
      drive(1'b0, 16'h0, 2'd0, 1'b1);
      check("stats_wrap", 64'(xfer_count), 64'd1);
      @(negedge clk);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
